// File: rtl/ciscud_control_unit_if.sv
// rtl/ciscud_control_unit_if.sv - strobe/status bundle between CiscUd control unit and datapath
// CISCUD_CU_ILLEGAL_TRAP_EN adds the illegal_op flag to the bundle.
interface ciscud_control_unit_if #(
  parameter int FUN_W = 4
);
  logic [15:0]      ir;
  logic             cond_in;
  logic             mem_ready;
  logic             load_pc;
  logic             load_ir;
  logic             load_ar;
  logic             load_dr;
  logic             load_s;
  logic [1:0]       sel_pc;
  logic             sel_ar;
  logic             sel_dr;
  logic             oe_pc_a;
  logic             oe_pc_d;
  logic             oe_ar;
  logic             oe_dr;
  logic             we_reg;
  logic             wsel;
  logic [2:0]       waddr;
  logic [2:0]       raddr_a;
  logic [2:0]       raddr_b;
  logic [FUN_W-1:0] fun;
  logic [1:0]       sel_s;
  logic             neg_s;
  logic             mem_rd;
  logic             mem_wr;
  logic             halted;
`ifdef CISCUD_CU_ILLEGAL_TRAP_EN
  logic             illegal_op;

  modport master (
    input  ir, cond_in, mem_ready,
    output load_pc, load_ir, load_ar, load_dr, load_s, sel_pc, sel_ar, sel_dr,
           oe_pc_a, oe_pc_d, oe_ar, oe_dr, we_reg, wsel, waddr, raddr_a, raddr_b,
           fun, sel_s, neg_s, mem_rd, mem_wr, halted, illegal_op
  );

  modport slave (
    output ir, cond_in, mem_ready,
    input  load_pc, load_ir, load_ar, load_dr, load_s, sel_pc, sel_ar, sel_dr,
           oe_pc_a, oe_pc_d, oe_ar, oe_dr, we_reg, wsel, waddr, raddr_a, raddr_b,
           fun, sel_s, neg_s, mem_rd, mem_wr, halted, illegal_op
  );
`else
  modport master (
    input  ir, cond_in, mem_ready,
    output load_pc, load_ir, load_ar, load_dr, load_s, sel_pc, sel_ar, sel_dr,
           oe_pc_a, oe_pc_d, oe_ar, oe_dr, we_reg, wsel, waddr, raddr_a, raddr_b,
           fun, sel_s, neg_s, mem_rd, mem_wr, halted
  );

  modport slave (
    output ir, cond_in, mem_ready,
    input  load_pc, load_ir, load_ar, load_dr, load_s, sel_pc, sel_ar, sel_dr,
           oe_pc_a, oe_pc_d, oe_ar, oe_dr, we_reg, wsel, waddr, raddr_a, raddr_b,
           fun, sel_s, neg_s, mem_rd, mem_wr, halted
  );
`endif
endinterface

// File: rtl/ciscud_control_unit.sv
// rtl/ciscud_control_unit.sv - multicycle fetch/decode/execute sequencer for the CiscUd datapath
// CISCUD_CU_ILLEGAL_TRAP_EN: illegal opcodes halt the unit and raise a sticky illegal_op.
module ciscud_control_unit #(
  parameter int               FUN_W      = 4,
  parameter logic [FUN_W-1:0] FUN_PASS_A = 4'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ciscud_control_unit_if.master cu
);

  typedef enum logic [3:0] {
    S_RESET,
    S_PCCLR,
    S_FETCH,
    S_DECODE,
    S_EXALU,
    S_LDI,
    S_LDAR,
    S_LDMEM,
    S_STAR,
    S_STDR,
    S_STMEM,
    S_TGT,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_ST   = 4'd3;
  localparam logic [3:0] OP_BR   = 4'd4;
  localparam logic [3:0] OP_JMP  = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd6;

  localparam logic [1:0] PC_DATOS = 2'd0;
  localparam logic [1:0] PC_CERO  = 2'd2;
  localparam logic [1:0] PC_INC   = 2'd3;

  state_e state_q, state_d;

  logic       is_alu;
  logic [3:0] op;
  logic [2:0] rd, ra, rb;
  logic       upd_s;
  logic       unused_ir0;

  assign is_alu     = cu.ir[15];
  assign op         = cu.ir[14:11];
  assign rd         = cu.ir[10:8];
  assign ra         = cu.ir[7:5];
  assign rb         = cu.ir[4:2];
  assign upd_s      = cu.ir[1];
  assign unused_ir0 = cu.ir[0];

  logic             load_pc, load_ir, load_ar, load_dr, load_s;
  logic [1:0]       sel_pc;
  logic             sel_ar, sel_dr;
  logic             oe_pc_a, oe_pc_d, oe_ar, oe_dr;
  logic             we_reg, wsel;
  logic [2:0]       waddr, raddr_a, raddr_b;
  logic [FUN_W-1:0] fun;
  logic [1:0]       sel_s;
  logic             neg_s;
  logic             mem_rd, mem_wr;
  logic             halted;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CISCUD_CU_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (state_q == S_DECODE && !is_alu && op > OP_HALT) begin
      illegal_q <= 1'b1;
    end
  end

  assign cu.illegal_op = illegal_q;
`endif

  always_comb begin
    state_d = state_q;
    load_pc = 1'b0;
    load_ir = 1'b0;
    load_ar = 1'b0;
    load_dr = 1'b0;
    load_s  = 1'b0;
    sel_pc  = 2'd0;
    sel_ar  = 1'b0;
    sel_dr  = 1'b0;
    oe_pc_a = 1'b0;
    oe_pc_d = 1'b0;
    oe_ar   = 1'b0;
    oe_dr   = 1'b0;
    we_reg  = 1'b0;
    wsel    = 1'b0;
    waddr   = 3'd0;
    raddr_a = 3'd0;
    raddr_b = 3'd0;
    fun     = '0;
    sel_s   = 2'd0;
    neg_s   = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    halted  = 1'b0;

    unique case (state_q)
      S_RESET: state_d = S_PCCLR;

      S_PCCLR: begin
        sel_pc  = PC_CERO;
        load_pc = 1'b1;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        oe_pc_a = 1'b1;
        mem_rd  = 1'b1;
        if (cu.mem_ready) begin
          load_ir = 1'b1;
          sel_pc  = PC_INC;
          load_pc = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (is_alu) begin
          state_d = S_EXALU;
        end else begin
          case (op)
            OP_NOP:         state_d = S_FETCH;
            OP_LDI:         state_d = S_LDI;
            OP_LD:          state_d = S_LDAR;
            OP_ST:          state_d = S_STAR;
            OP_BR, OP_JMP:  state_d = S_TGT;
            OP_HALT:        state_d = S_HALT;
`ifdef CISCUD_CU_ILLEGAL_TRAP_EN
            default:        state_d = S_HALT;
`else
            default:        state_d = S_FETCH;
`endif
          endcase
        end
      end

      S_EXALU: begin
        raddr_a = ra;
        raddr_b = rb;
        fun     = cu.ir[14:11];
        we_reg  = 1'b1;
        waddr   = rd;
        wsel    = 1'b0;
        load_s  = upd_s;
        state_d = S_FETCH;
      end

      S_LDI: begin
        oe_pc_a = 1'b1;
        mem_rd  = 1'b1;
        if (cu.mem_ready) begin
          we_reg  = 1'b1;
          wsel    = 1'b1;
          waddr   = rd;
          sel_pc  = PC_INC;
          load_pc = 1'b1;
          state_d = S_FETCH;
        end
      end

      // LD and ST share the address phase: AR <- ra through the ALU.
      S_LDAR, S_STAR: begin
        raddr_a = ra;
        fun     = FUN_PASS_A;
        sel_ar  = 1'b1;
        load_ar = 1'b1;
        state_d = (state_q == S_LDAR) ? S_LDMEM : S_STDR;
      end

      S_LDMEM: begin
        oe_ar  = 1'b1;
        mem_rd = 1'b1;
        if (cu.mem_ready) begin
          we_reg  = 1'b1;
          wsel    = 1'b1;
          waddr   = rd;
          state_d = S_FETCH;
        end
      end

      S_STDR: begin
        raddr_a = rd;
        fun     = FUN_PASS_A;
        sel_dr  = 1'b1;
        load_dr = 1'b1;
        state_d = S_STMEM;
      end

      S_STMEM: begin
        oe_ar  = 1'b1;
        oe_dr  = 1'b1;
        mem_wr = 1'b1;
        if (cu.mem_ready) begin
          state_d = S_FETCH;
        end
      end

      // Target word is on Datos; a not-taken branch just skips it via PC+1.
      S_TGT: begin
        oe_pc_a = 1'b1;
        mem_rd  = 1'b1;
        sel_s   = cu.ir[7:6];
        neg_s   = cu.ir[5];
        if (cu.mem_ready) begin
          load_pc = 1'b1;
          sel_pc  = (op == OP_JMP || cu.cond_in) ? PC_DATOS : PC_INC;
          state_d = S_FETCH;
        end
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_RESET;
    endcase
  end

  assign cu.load_pc = load_pc;
  assign cu.load_ir = load_ir;
  assign cu.load_ar = load_ar;
  assign cu.load_dr = load_dr;
  assign cu.load_s  = load_s;
  assign cu.sel_pc  = sel_pc;
  assign cu.sel_ar  = sel_ar;
  assign cu.sel_dr  = sel_dr;
  assign cu.oe_pc_a = oe_pc_a;
  assign cu.oe_pc_d = oe_pc_d;
  assign cu.oe_ar   = oe_ar;
  assign cu.oe_dr   = oe_dr;
  assign cu.we_reg  = we_reg;
  assign cu.wsel    = wsel;
  assign cu.waddr   = waddr;
  assign cu.raddr_a = raddr_a;
  assign cu.raddr_b = raddr_b;
  assign cu.fun     = fun;
  assign cu.sel_s   = sel_s;
  assign cu.neg_s   = neg_s;
  assign cu.mem_rd  = mem_rd;
  assign cu.mem_wr  = mem_wr;
  assign cu.halted  = halted;

endmodule

// File: tb/tb_ciscud_control_unit.sv
// tb/tb_ciscud_control_unit.sv - directed-vector bench for ciscud_control_unit
module tb_ciscud_control_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   viol = 0;
  int   we_count;

  ciscud_control_unit_if #(.FUN_W(4)) bus ();

  ciscud_control_unit #(.FUN_W(4), .FUN_PASS_A(4'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cu    (bus.master)
  );

  always #5 clk = ~clk;

  // halted sits at bit 0 so "only halted" compares against 1
  logic [33:0] all_o;
  assign all_o = {bus.load_pc, bus.load_ir, bus.load_ar, bus.load_dr, bus.load_s,
                  bus.sel_pc, bus.sel_ar, bus.sel_dr,
                  bus.oe_pc_a, bus.oe_pc_d, bus.oe_ar, bus.oe_dr,
                  bus.we_reg, bus.wsel, bus.waddr, bus.raddr_a, bus.raddr_b,
                  bus.fun, bus.sel_s, bus.neg_s, bus.mem_rd, bus.mem_wr, bus.halted};

  always @(negedge clk) begin
    if ((bus.mem_rd && bus.mem_wr) || (bus.oe_pc_a && bus.oe_ar) || bus.oe_pc_d)
      viol++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at a FETCH negedge with mem_ready=1; leaves at the DECODE negedge.
  task automatic fetch_decode(input logic [15:0] word);
    bus.ir = word;
    #1;
    check("fetch", {bus.oe_pc_a, bus.mem_rd, bus.load_ir, bus.load_pc, bus.sel_pc}, 6'h3F);
    step();
    check("decode_quiet", all_o, 34'd0);
  endtask

  task automatic reset_to_fetch();
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    step();
    check("reset_quiet", all_o, 34'd0);
    rst_n = 1'b1;
    step();
    check("pcclr", {bus.load_pc, bus.sel_pc, bus.mem_rd, bus.oe_pc_a}, 5'b11000);
    step();
  endtask

  initial begin
    bus.ir        = 16'h0000;
    bus.cond_in   = 1'b0;
    bus.mem_ready = 1'b1;
    rst_n         = 1'b0;

    @(negedge clk);
    check("rst_cycle1", all_o, 34'd0);
    step();
    check("rst_cycle2", all_o, 34'd0);
    rst_n = 1'b1;
    step();
    check("pcclr", {bus.load_pc, bus.sel_pc, bus.mem_rd}, 4'b1100);
    step();

    // ALU fun=4 rd=3 ra=2 rb=4 upd=1
    fetch_decode(16'hA352);
    step();
    check("exalu", {bus.we_reg, bus.wsel, bus.waddr, bus.raddr_a, bus.raddr_b, bus.fun, bus.load_s},
          {1'b1, 1'b0, 3'd3, 3'd2, 3'd4, 4'd4, 1'b1});
    step();

    // LD r5 <- M[r1], three wait states
    fetch_decode(16'h1520);
    step();
    check("ldar", {bus.raddr_a, bus.fun, bus.sel_ar, bus.load_ar}, {3'd1, 4'd0, 1'b1, 1'b1});
    bus.mem_ready = 1'b0;
    we_count = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.mem_ready = (i == 3);
      #1;
      check("ldmem_hold", {bus.oe_ar, bus.mem_rd, bus.oe_pc_a}, 3'b110);
      if (bus.we_reg) we_count++;
    end
    check("ldmem_write", {bus.we_reg, bus.wsel, bus.waddr}, {1'b1, 1'b1, 3'd5});
    check("ld_we_once", we_count, 1);
    step();

    // BR sel_s=3 neg=0, not taken then taken
    for (int c = 0; c < 2; c++) begin
      bus.cond_in = c[0];
      fetch_decode(16'h20C0);
      step();
      check("br_tgt", {bus.oe_pc_a, bus.mem_rd, bus.sel_s, bus.neg_s, bus.load_pc, bus.sel_pc},
            {1'b1, 1'b1, 2'd3, 1'b0, 1'b1, (c == 1) ? 2'd0 : 2'd3});
      step();
    end

    bus.cond_in = 1'b0;
    fetch_decode(16'h2800);
    step();
    check("jmp_tgt", {bus.load_pc, bus.sel_pc, bus.mem_rd}, {1'b1, 2'd0, 1'b1});
    step();

    // LDI r7
    fetch_decode(16'h0F00);
    step();
    check("ldi", {bus.oe_pc_a, bus.mem_rd, bus.we_reg, bus.wsel, bus.waddr, bus.load_pc, bus.sel_pc},
          {1'b1, 1'b1, 1'b1, 1'b1, 3'd7, 1'b1, 2'd3});
    step();

    // ST M[r6] <- r2, reset while waiting in STMEM
    fetch_decode(16'h1AC0);
    step();
    check("star", {bus.raddr_a, bus.sel_ar, bus.load_ar}, {3'd6, 1'b1, 1'b1});
    step();
    check("stdr", {bus.raddr_a, bus.fun, bus.sel_dr, bus.load_dr}, {3'd2, 4'd0, 1'b1, 1'b1});
    bus.mem_ready = 1'b0;
    step();
    check("stmem", {bus.oe_ar, bus.oe_dr, bus.mem_wr, bus.mem_rd}, 4'b1110);
    step();
    check("stmem_wait", {bus.oe_ar, bus.oe_dr, bus.mem_wr, bus.mem_rd}, 4'b1110);
    reset_to_fetch();

    // op 7 illegal
    fetch_decode(16'h3800);
    step();
`ifdef CISCUD_CU_ILLEGAL_TRAP_EN
    check("illegal_trap", {bus.illegal_op, all_o}, {1'b1, 34'd1});
    step();
    step();
    check("illegal_hold", {bus.illegal_op, bus.halted}, 2'b11);
    reset_to_fetch();
    check("illegal_clear", {bus.illegal_op, bus.halted}, 2'b00);
`else
    check("illegal_nop", {bus.oe_pc_a, bus.mem_rd, bus.halted}, 3'b110);
`endif

    fetch_decode(16'h3000);
    step();
    check("halt", all_o, 34'd1);
    for (int i = 0; i < 3; i++) step();
    check("halt_hold", all_o, 34'd1);
    reset_to_fetch();
    check("after_halt", {bus.halted, bus.oe_pc_a, bus.mem_rd}, 3'b011);

    check("exclusion", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
